// File: rtl/demorgan_checker.sv
// Stimulus/response checker for the two-input De Morgan gate block: sweeps A/B
// through all four vectors, samples the six gate outputs and keeps pass/fail diagnostics.
module demorgan_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             drv_a,
    output logic             drv_b,
    input  logic [5:0]       obs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       fail_mask,
    output logic [1:0]       first_fail_vec,
    output logic [5:0]       first_fail_bits,
    output logic [1:0]       dbgState
);

    // Handshake: start is a single-cycle request honoured only in IDLE (abort wins
    // if both are high); done is a single-cycle pulse in DONE; busy covers SETTLE..DONE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } stateE;

    localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LastPass   = 8'(PASSES - 1);

    stateE      state;
    stateE      stateNext;
    logic [1:0] vecIdx;
    logic [7:0] passIdx;
    logic [7:0] settleCnt;
    logic       anyErr;

    logic       launch;
    logic       abortNow;
    logic       sampleNow;
    logic       settleEnd;
    logic       lastSample;
    logic [5:0] expected;
    logic [5:0] diff;
    logic       mismatch;

    function automatic logic [5:0] golden(input logic [1:0] v);
        logic a;
        logic b;
        a = v[1];
        b = v[0];
        return {~a, ~b, ~a & ~b, ~(a | b), ~a | ~b, ~(a & b)};
    endfunction

    assign expected   = golden(vecIdx);
    assign diff       = obs ^ expected;
    assign mismatch   = |diff;
    assign settleEnd  = (settleCnt == SettleLast);
    assign lastSample = (vecIdx == 2'd3) && (passIdx == LastPass);

    assign drv_a    = vecIdx[1];
    assign drv_b    = vecIdx[0];
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign dbgState = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        launch    = 1'b0;
        abortNow  = 1'b0;
        sampleNow = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    launch    = 1'b1;
                    stateNext = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    abortNow  = 1'b1;
                    stateNext = IDLE;
                end else if (settleEnd) begin
                    stateNext = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    abortNow  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    sampleNow = 1'b1;
                    stateNext = lastSample ? DONE : SETTLE;
                end
            end
            DONE: begin
                abortNow  = abort;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Vector, pass and settle sequencing; the vector register drives A/B directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vecIdx    <= 2'd0;
            passIdx   <= 8'd0;
            settleCnt <= 8'd0;
        end else if (launch || abortNow) begin
            vecIdx    <= 2'd0;
            passIdx   <= 8'd0;
            settleCnt <= 8'd0;
        end else begin
            case (state)
                SETTLE: settleCnt <= settleEnd ? 8'd0 : settleCnt + 8'd1;
                SAMPLE: begin
                    if (sampleNow && !lastSample) begin
                        vecIdx <= vecIdx + 2'd1;
                        if (vecIdx == 2'd3) begin
                            passIdx <= passIdx + 8'd1;
                        end
                    end
                end
                DONE: begin
                    vecIdx  <= 2'd0;
                    passIdx <= 8'd0;
                end
                default: ;
            endcase
        end
    end

    // anyErr is kept apart from err_count so a saturated count never hides the verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count       <= '0;
            fail_mask       <= 4'd0;
            first_fail_vec  <= 2'd0;
            first_fail_bits <= 6'd0;
            anyErr          <= 1'b0;
            pass            <= 1'b0;
        end else if (launch) begin
            err_count       <= '0;
            fail_mask       <= 4'd0;
            first_fail_vec  <= 2'd0;
            first_fail_bits <= 6'd0;
            anyErr          <= 1'b0;
            pass            <= 1'b0;
        end else if (abortNow) begin
            pass <= 1'b0;
        end else if (sampleNow) begin
            if (mismatch) begin
                if (err_count != '1) begin
                    err_count <= err_count + CNT_W'(1);
                end
                fail_mask[vecIdx] <= 1'b1;
                anyErr            <= 1'b1;
                if (!anyErr) begin
                    first_fail_vec  <= vecIdx;
                    first_fail_bits <= diff;
                end
            end
            if (lastSample) begin
                pass <= !(anyErr || mismatch);
            end
        end
    end

endmodule

// File: tb/tb_demorgan_checker.sv
// Directed bench for demorgan_checker: three parameterisations, each fed by a gate
// model whose outputs can be forced stuck-at-0, stuck-at-1 or inverted per bit.
module tb_demorgan_checker;

    logic       clk;
    logic       rst_n;
    logic       start [3];
    logic       abort [3];
    logic [5:0] obs [3];
    logic       drvA [3];
    logic       drvB [3];
    logic       busy [3];
    logic       done [3];
    logic       pass [3];
    logic [3:0] failMask [3];
    logic [1:0] ffVec [3];
    logic [5:0] ffBits [3];
    logic [1:0] dbg [3];
    logic [7:0] errCnt0;
    logic [7:0] errCnt1;
    logic [1:0] errCnt2;

    logic [5:0] sa0 [3];
    logic [5:0] sa1 [3];
    logic [5:0] inv [3];

    logic [1:0] expQ[$];
    int         nVec;
    int         nMiss;
    int         edgeNow;

    demorgan_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .drv_a(drvA[0]), .drv_b(drvB[0]), .obs(obs[0]), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .err_count(errCnt0), .fail_mask(failMask[0]),
        .first_fail_vec(ffVec[0]), .first_fail_bits(ffBits[0]), .dbgState(dbg[0])
    );

    demorgan_checker #(.PASSES(3)) u_p3 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .drv_a(drvA[1]), .drv_b(drvB[1]), .obs(obs[1]), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .err_count(errCnt1), .fail_mask(failMask[1]),
        .first_fail_vec(ffVec[1]), .first_fail_bits(ffBits[1]), .dbgState(dbg[1])
    );

    demorgan_checker #(.CNT_W(2), .PASSES(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
        .drv_a(drvA[2]), .drv_b(drvB[2]), .obs(obs[2]), .busy(busy[2]),
        .done(done[2]), .pass(pass[2]), .err_count(errCnt2), .fail_mask(failMask[2]),
        .first_fail_vec(ffVec[2]), .first_fail_bits(ffBits[2]), .dbgState(dbg[2])
    );

    function automatic logic [5:0] gate(input logic a, input logic b);
        return {~a, ~b, ~a & ~b, ~(a | b), ~a | ~b, ~(a & b)};
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            obs[i] = ((gate(drvA[i], drvB[i]) & ~sa0[i]) | sa1[i]) ^ inv[i];
        end
    end

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMiss++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edgeNow);
        end
    endtask

    // Drivers: start sampled at edge 0; afterwards we sit at the negedge following edge 0.
    task automatic launch(input int which);
        @(negedge clk);
        start[which] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[which] = 1'b0;
        edgeNow = 0;
    endtask

    task automatic stepTo(input int e);
        while (edgeNow < e) begin
            @(negedge clk);
            edgeNow++;
        end
    endtask

    initial begin
        nVec    = 0;
        nMiss   = 0;
        edgeNow = 0;
        rst_n   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            abort[i] = 1'b0;
            sa0[i]   = 6'd0;
            sa1[i]   = 6'd0;
            inv[i]   = 6'd0;
        end
        repeat (2) @(negedge clk);
        checkVal("rst_drv", {30'd0, drvA[0], drvB[0]}, 0);
        checkVal("rst_busy", busy[0], 0);
        checkVal("rst_done", done[0], 0);
        checkVal("rst_pass", pass[0], 0);
        checkVal("rst_err", errCnt0, 0);
        checkVal("rst_mask", failMask[0], 0);
        checkVal("rst_ffv", ffVec[0], 0);
        checkVal("rst_ffb", ffBits[0], 0);
        checkVal("rst_state", dbg[0], 0);
        rst_n = 1'b1;

        // Clean gate, defaults: drive sequence, done at edge 12, pass.
        for (int v = 0; v < 4; v++) begin
            repeat (3) expQ.push_back(2'(v));
        end
        launch(0);
        for (int e = 0; e < 12; e++) begin
            stepTo(e);
            checkVal("clean_drv", {30'd0, drvA[0], drvB[0]}, {30'd0, expQ.pop_front()});
            checkVal("clean_no_early_done", done[0], 0);
        end
        stepTo(12);
        checkVal("clean_done", done[0], 1);
        checkVal("clean_busy", busy[0], 1);
        checkVal("clean_pass", pass[0], 1);
        checkVal("clean_err", errCnt0, 0);
        checkVal("clean_mask", failMask[0], 0);
        stepTo(13);
        checkVal("clean_done_pulse", done[0], 0);
        checkVal("clean_idle", busy[0], 0);
        checkVal("clean_pass_held", pass[0], 1);

        // obs[0] stuck at 0: vectors 0,1,2 mismatch.
        sa0[0] = 6'b000001;
        launch(0);
        stepTo(12);
        checkVal("sa0_done", done[0], 1);
        checkVal("sa0_err", errCnt0, 3);
        checkVal("sa0_mask", failMask[0], 4'b0111);
        checkVal("sa0_ffv", ffVec[0], 0);
        checkVal("sa0_ffb", ffBits[0], 6'b000001);
        checkVal("sa0_pass", pass[0], 0);
        sa0[0] = 6'd0;

        // PASSES=3, obs[2] stuck at 1: vectors 1,2,3 fail every pass.
        sa1[1] = 6'b000100;
        launch(1);
        stepTo(35);
        checkVal("p3_not_done_35", done[1], 0);
        stepTo(36);
        checkVal("p3_done_36", done[1], 1);
        checkVal("p3_err", errCnt1, 9);
        checkVal("p3_mask", failMask[1], 4'b1110);
        checkVal("p3_ffv", ffVec[1], 1);
        checkVal("p3_ffb", ffBits[1], 6'b000100);
        checkVal("p3_pass", pass[1], 0);

        // CNT_W=2, PASSES=2, everything inverted: count saturates at 3.
        inv[2] = 6'b111111;
        launch(2);
        stepTo(24);
        checkVal("sat_done", done[2], 1);
        checkVal("sat_err", errCnt2, 3);
        checkVal("sat_mask", failMask[2], 4'b1111);
        checkVal("sat_ffb", ffBits[2], 6'b111111);
        checkVal("sat_pass", pass[2], 0);

        // start re-asserted at edges 3 and 7, in the DONE cycle, then one cycle later.
        launch(0);
        stepTo(2);
        start[0] = 1'b1;
        stepTo(3);
        start[0] = 1'b0;
        stepTo(6);
        start[0] = 1'b1;
        stepTo(7);
        start[0] = 1'b0;
        checkVal("rs_drv_e7", {30'd0, drvA[0], drvB[0]}, 2'b10);
        stepTo(11);
        checkVal("rs_not_done_11", done[0], 0);
        stepTo(12);
        checkVal("rs_done_12", done[0], 1);
        checkVal("rs_pass", pass[0], 1);
        checkVal("rs_err", errCnt0, 0);
        start[0] = 1'b1;
        stepTo(13);
        checkVal("rs_done_cycle_ignored", busy[0], 0);
        checkVal("rs_pass_kept", pass[0], 1);
        stepTo(14);
        start[0] = 1'b0;
        checkVal("rs_relaunch_busy", busy[0], 1);
        checkVal("rs_relaunch_pass_clr", pass[0], 0);
        abort[0] = 1'b1;
        stepTo(15);
        abort[0] = 1'b0;
        checkVal("rs_abort_idle", busy[0], 0);

        // Abort at edge 5, then a clean rerun.
        launch(0);
        stepTo(5);
        abort[0] = 1'b1;
        stepTo(6);
        abort[0] = 1'b0;
        checkVal("ab_busy", busy[0], 0);
        checkVal("ab_state", dbg[0], 0);
        checkVal("ab_drv", {30'd0, drvA[0], drvB[0]}, 0);
        checkVal("ab_done", done[0], 0);
        checkVal("ab_pass", pass[0], 0);
        stepTo(14);
        checkVal("ab_no_late_done", done[0], 0);
        launch(0);
        stepTo(12);
        checkVal("ab_rerun_done", done[0], 1);
        checkVal("ab_rerun_pass", pass[0], 1);

        // Asynchronous reset in the middle of SETTLE for vector 1.
        sa0[0] = 6'b000001;
        launch(0);
        stepTo(4);
        checkVal("mr_pre_err", errCnt0, 1);
        checkVal("mr_pre_drv", {30'd0, drvA[0], drvB[0]}, 2'b01);
        checkVal("mr_pre_state", dbg[0], 1);
        #2 rst_n = 1'b0;
        #1;
        checkVal("mr_drv", {30'd0, drvA[0], drvB[0]}, 0);
        checkVal("mr_busy", busy[0], 0);
        checkVal("mr_done", done[0], 0);
        checkVal("mr_err", errCnt0, 0);
        checkVal("mr_mask", failMask[0], 0);
        checkVal("mr_ffb", ffBits[0], 0);
        checkVal("mr_state", dbg[0], 0);
        @(negedge clk);
        rst_n  = 1'b1;
        sa0[0] = 6'd0;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
